// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: detects each byte by a change in the
// receiver's completion counter and queues it in a first-word-fall-through FIFO.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          bclk,
    input  logic          reset,
    input  logic [7:0]    rhr_data,
    input  logic [7:0]    data_ready,
    input  logic          rd_en,
    input  logic          clr_overrun,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun
);

    logic [7:0]    mem [DEPTH];
    logic [7:0]    rdy_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          wr_ok;

    // Any change of the counter is one new byte, so 255->0 counts like every other step.
    assign push  = (data_ready != rdy_q);
    assign pop   = rd_en && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign wr_ok = push && (!full || pop);

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge bclk) begin
        if (wr_ok)
            mem[wr_ptr] <= rhr_data;
    end

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            rdy_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            rdy_q <= data_ready;
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // A dropped byte outranks a clear issued in the same cycle.
            if (push && !wr_ok)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a monitor checks
// every accepted pop against the queue head; flags and count are checked directly.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          bclk = 1'b0;
    logic          reset;
    logic [7:0]    rhr_data;
    logic [7:0]    data_ready;
    logic          rd_en;
    logic          clr_overrun;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .bclk        (bclk),
        .reset       (reset),
        .rhr_data    (rhr_data),
        .data_ready  (data_ready),
        .rd_en       (rd_en),
        .clr_overrun (clr_overrun),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun)
    );

    always #5 bclk = ~bclk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge bclk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit accept);
        rhr_data   = b;
        data_ready = data_ready + 8'd1;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        cycles(n);
        rd_en = 1'b0;
    endtask

    // Monitor: a pop is taken at the next edge whenever rd_en=1 and empty=0.
    always @(negedge bclk) begin
        if (!reset && rd_en && !empty) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no data", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; rhr_data = 8'h00; data_ready = 8'h00;
        rd_en = 1'b0; clr_overrun = 1'b0;
        cycles(3);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            check("idle_flags", {empty, full, overrun, count}, {1'b1, 1'b0, 1'b0, 4'd0});
        end

        // Single byte, one-cycle write latency
        send(8'h5A, 1'b1);
        cycles(1);
        check("one_count", count, 1);
        check("one_empty", empty, 0);
        check("one_data", rd_data, 8'h5A);
        drain(1);
        check("one_drained_count", count, 0);
        check("one_drained_empty", empty, 1);
        cycles(10);

        // Fill, then overflow
        for (int i = 0; i < 8; i++) begin
            send(8'h10 + 8'(i), 1'b1);
            cycles(10);
        end
        check("fill_full", full, 1);
        check("fill_count", count, 8);
        check("fill_overrun", overrun, 0);
        send(8'h99, 1'b0);
        cycles(10);
        check("drop_overrun", overrun, 1);
        check("drop_count", count, 8);
        clr_overrun = 1'b1;
        cycles(1);
        clr_overrun = 1'b0;
        check("clr_overrun", overrun, 0);

        // Full FIFO: push and pop in the same cycle
        send(8'hA0, 1'b1);
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
        check("simul_count", count, 8);
        check("simul_overrun", overrun, 0);
        check("simul_head", rd_data, 8'h11);
        cycles(9);
        drain(8);
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);

        // Counter wrap 0xFF -> 0x00
        rhr_data = 8'h77; data_ready = 8'hFF; exp_q.push_back(8'h77);
        cycles(10);
        drain(1);
        cycles(9);
        send(8'hC3, 1'b1);
        cycles(1);
        check("wrap_count", count, 1);
        check("wrap_data", rd_data, 8'hC3);
        cycles(9);
        check("wrap_single_push", count, 1);
        drain(1);
        check("wrap_empty", empty, 1);
        cycles(9);

        // Overrun set beats a same-cycle clear
        for (int i = 0; i < 8; i++) begin
            send(8'h20 + 8'(i), 1'b1);
            cycles(10);
        end
        send(8'h98, 1'b0);
        clr_overrun = 1'b1;
        cycles(1);
        clr_overrun = 1'b0;
        check("set_beats_clear", overrun, 1);
        check("set_beats_count", count, 8);
        cycles(9);

        // Asynchronous reset with five bytes stored
        drain(3);
        check("pre_reset_count", count, 5);
        #3;
        reset = 1'b1; data_ready = 8'h00;
        #1;
        check("async_count", count, 0);
        check("async_empty", empty, 1);
        check("async_overrun", overrun, 0);
        exp_q.delete();
        cycles(2);
        reset = 1'b0;
        cycles(5);
        check("post_reset_empty", empty, 1);
        send(8'h42, 1'b1);
        cycles(1);
        check("post_reset_count", count, 1);
        check("post_reset_data", rd_data, 8'h42);
        drain(1);
        cycles(2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
